// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - lock-and-track monitor for an enable-gated up-counter
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int SYNC_LEN = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] counter_in,
  input  logic             clr_stats,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  // good_cnt only ever holds 0..SYNC_LEN-1; the final good transition locks instead of storing
  localparam int GW = (SYNC_LEN < 2) ? 1 : $clog2(SYNC_LEN);
  localparam logic [GW-1:0]    GOOD_LAST = GW'(SYNC_LEN - 1);
  localparam logic [WIDTH-1:0] VAL_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev_val;
  logic             prev_en;
  logic [GW-1:0]    good_cnt;
  logic [WIDTH-1:0] expected;
  logic             match;
  logic             wrap_seen;

  // Predict this cycle's value from last cycle's sample; the increment wraps naturally
  always_comb begin
    expected  = prev_en ? (prev_val + WIDTH'(1)) : prev_val;
    match     = (counter_in == expected);
    wrap_seen = prev_en && (prev_val == VAL_MAX);
  end

  // Sampling, acquire/lock FSM, pulses and saturating statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      prev_val   <= '0;
      prev_en    <= 1'b0;
      good_cnt   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      prev_val   <= counter_in;
      prev_en    <= en;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;

      case (state)
        IDLE: begin
          // No valid previous sample yet, so nothing to compare against
          state    <= ACQ;
          good_cnt <= '0;
          locked   <= 1'b0;
        end

        ACQ: begin
          // Mismatches here are silent: one error is reported per loss of lock
          if (match) begin
            if (good_cnt == GOOD_LAST) begin
              state    <= LOCKED;
              good_cnt <= '0;
              locked   <= 1'b1;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end else begin
            good_cnt <= '0;
          end
        end

        LOCKED: begin
          if (!match) begin
            err_pulse <= 1'b1;
            if (err_count != CNT_MAX) begin
              err_count <= err_count + CNT_W'(1);
            end
            state    <= ACQ;
            good_cnt <= '0;
            locked   <= 1'b0;
          end else if (wrap_seen) begin
            wrap_pulse <= 1'b1;
            if (wrap_count != CNT_MAX) begin
              wrap_count <= wrap_count + CNT_W'(1);
            end
          end
        end

        default: begin
          state    <= IDLE;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase

      // Clear takes priority over a same-edge increment; the pulses are unaffected
      if (clr_stats) begin
        err_count  <= '0;
        wrap_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - directed scoreboard bench for count_seq_checker
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] counter_in;
  logic       clr_stats;
  logic       locked;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  logic [7:0] m_ec = 8'd0;
  logic [7:0] m_wc = 8'd0;
  logic [3:0] cur;

  typedef struct packed {
    logic       lk;
    logic       er;
    logic       wr;
    logic [7:0] ec;
    logic [7:0] wc;
  } exp_t;

  exp_t sb[$];

  count_seq_checker #(.WIDTH(4), .SYNC_LEN(2), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .counter_in (counter_in),
    .clr_stats  (clr_stats),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, push the outputs expected after the edge, then pop and compare
  task automatic step(input logic r, input logic e, input logic [3:0] v, input logic c,
                      input logic lk, input logic er, input logic wr);
    exp_t x;
    reset      = r;
    en         = e;
    counter_in = v;
    clr_stats  = c;
    if (!r) begin
      m_ec = 8'd0;
      m_wc = 8'd0;
    end else begin
      if (er && m_ec != 8'hff) m_ec = m_ec + 8'd1;
      if (wr && m_wc != 8'hff) m_wc = m_wc + 8'd1;
      if (c) begin
        m_ec = 8'd0;
        m_wc = 8'd0;
      end
    end
    x = '{lk: lk, er: er, wr: wr, ec: m_ec, wc: m_wc};
    sb.push_back(x);
    @(posedge clk);
    #1;
    step_no++;
    x = sb.pop_front();
    check("locked",     {7'd0, locked},     {7'd0, x.lk});
    check("err_pulse",  {7'd0, err_pulse},  {7'd0, x.er});
    check("wrap_pulse", {7'd0, wrap_pulse}, {7'd0, x.wr});
    check("err_count",  err_count,  x.ec);
    check("wrap_count", wrap_count, x.wc);
  endtask

  // From a locked hold (en=0) at cur: jump to another value, then relock on it
  task automatic force_error();
    logic [3:0] nv;
    nv = (cur == 4'd12) ? 4'd13 : 4'd12;
    step(1, 0, nv, 0, 0, 1, 0);
    step(1, 0, nv, 0, 0, 0, 0);
    step(1, 0, nv, 0, 1, 0, 0);
    cur = nv;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; counter_in = 4'd0; clr_stats = 1'b0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0, 0);

    // Hold at 0: IDLE -> ACQ -> ACQ -> LOCKED on the third edge
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);

    // Count 0..15 then 0: single wrap pulse after 0 is sampled
    for (int i = 0; i < 16; i++) step(1, 1, 4'(i), 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1, 0, 0);

    // Counter reset from 7 while locked: one error, relock after holding 0
    for (int i = 1; i < 8; i++) step(1, 1, 4'(i), 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);

    // Jump 5 -> 9 while counting: error, relock after 10, 11
    for (int i = 0; i < 6; i++) step(1, 1, 4'(i), 0, 1, 0, 0);
    step(1, 1, 9, 0, 0, 1, 0);
    step(1, 1, 10, 0, 0, 0, 0);
    step(1, 1, 11, 0, 1, 0, 0);
    step(1, 0, 12, 0, 1, 0, 0);
    cur = 4'd12;

    // Drive err_count to saturation and beyond; pulses keep firing
    for (int k = 0; k < 254; k++) force_error();
    check("err_count_sat", err_count, 8'hff);

    // Count up to a wrap with clr_stats on the wrapping edge
    step(1, 1, cur, 0, 1, 0, 0);
    for (int i = int'(cur) + 1; i < 16; i++) step(1, 1, 4'(i), 0, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 1);
    step(1, 0, 1, 0, 1, 0, 0);
    cur = 4'd1;

    // Three errors, then reset mid-count while locked
    for (int k = 0; k < 3; k++) force_error();
    check("err_count_3", err_count, 8'd3);
    step(1, 1, cur, 0, 1, 0, 0);
    step(1, 1, cur + 4'd1, 0, 1, 0, 0);
    step(0, 1, cur + 4'd2, 0, 0, 0, 0);

    // Relock needs SYNC_LEN+1 edges after release
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side monitor for the team's enable-gated up-counter.
- Samples the counter's output and enable every clock, predicts the next value, and acquires lock after a run of correct transitions.
- While locked, flags sequence errors and counts errors and wrap-arounds.
- Sits beside the counter in benches and on-board self-test; the counter drives it and it never drives the counter.

Parameters:
- WIDTH, 4, width of the observed count.
- SYNC_LEN, 2, consecutive correct transitions required to lock (>=1).
- CNT_W, 8, width of the err_count and wrap_count statistics counters.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  enable seen by the observed counter in the same cycle.
- counter_in  input  WIDTH  observed counter value.
- clr_stats  input  1  synchronous clear of err_count and wrap_count.
- locked  output  1  high while tracking the sequence.
- err_pulse  output  1  one-cycle pulse per detected sequence error.
- wrap_pulse  output  1  one-cycle pulse per observed wrap while locked.
- err_count  output  CNT_W  saturating number of errors.
- wrap_count  output  CNT_W  saturating number of wraps.

Behaviour:
- Reset: reset low at a rising edge clears all outputs and internal registers. State becomes IDLE, and prev_val, prev_en, good_cnt, locked, err_pulse, wrap_pulse, err_count and wrap_count all become 0. Reset overrides every other input.
- Sampling: every edge with reset high captures prev_val<=counter_in and prev_en<=en, in all states.
- Prediction: expected = prev_en ? prev_val+1 : prev_val, modulo 2^WIDTH (carry discarded). match = (counter_in == expected).
- FSM state IDLE: no valid previous sample. Next edge goes to ACQ with good_cnt=0 and does no comparison.
- FSM state ACQ:
  - match: good_cnt++. When good_cnt+1 == SYNC_LEN, go to LOCKED and clear good_cnt.
  - mismatch: good_cnt=0, no error reported.
- FSM state LOCKED:
  - mismatch: err_pulse=1 next cycle, err_count++ (saturates at all-ones), go to ACQ with good_cnt=0.
  - match with prev_en=1 and prev_val=2^WIDTH-1 (i.e. counter_in=0): wrap_pulse=1 next cycle, wrap_count++ (saturating).
- locked is 1 exactly when the state is LOCKED, registered.
- Latency: pulses and count updates are visible one cycle after the edge sampling the offending or wrapping value.
- Pulses are high for exactly one cycle and default to 0.
- Hold (en=0) while locked is not an error as long as the value is unchanged.
- A jump caused by the counter's own reset while locked is reported as one error, followed by re-acquire.
- clr_stats: both counts become 0 at that edge. If an error or wrap occurs on the same edge, clr wins (count=0), but the pulse still fires. clr_stats does not affect the FSM or locked.
- Saturation: at all-ones the counts hold, and pulses still fire.
- After an error, no further error is reported until lock is re-acquired. This gives one error per loss of lock.

Test Plan:
- Release reset, hold en=0 with counter_in=0 for 4 cycles -> locked=1 after the third edge with reset high (IDLE->ACQ->ACQ->LOCKED). err_count=0, no pulses.
- Locked, en=1 counting 0..15 then 0 -> exactly one wrap_pulse, the cycle after counter_in=0 is sampled. wrap_count=1, err_pulse never high.
- Locked at counter_in=5 with en=1, then force counter_in=9 -> err_pulse for one cycle, err_count=1, locked drops. Locked returns after 2 further correct transitions (10, 11).
- Locked at 7, apply the counter's reset so counter_in=0 while en=0 -> single error, err_count=1. Holding 0 for 3 cycles -> relock, no further errors.
- Preload err_count=255 via repeated errors, then one more error -> err_count stays 255 and err_pulse still asserted. Assert clr_stats on the same edge as a wrap -> wrap_count=0 and wrap_pulse=1.
- Assert reset low mid-count while locked with err_count=3 -> next cycle every output is 0 and the state is IDLE. Relock requires SYNC_LEN+1 edges after release.
